ram_arbiter: RTL
================

// Module: ram_arbiter
// PURPOSE
//  Shares the single-port synchronous RAM of the basic processor between two
//  requesters: port 0 (processor memory interface) and port 1 (display/DMA
//  reader). Arbitrates with round-robin or fixed priority. Runs one registered
//  access at a time and returns a completion pulse plus read data per port.
// PARAMETERS
//  WORD_W      8  data width of RAM words and of both ports
//  ADDR_W      5  RAM address width
//  FIXED_PRIO  0  0 = round-robin between ports; 1 = port 0 always wins ties
// PORTS
//  clock       in   1       system clock, rising edge
//  n_reset     in   1       asynchronous, active-low reset
//  req0/req1   in   1       access request, held until gntN seen
//  rnw0/rnw1   in   1       1 = read, 0 = write; valid while reqN high
//  addr0/addr1 in   ADDR_W  access address; valid while reqN high
//  wdata0/1    in   WORD_W  write data; valid while reqN high
//  gnt0/gnt1   out  1       one-cycle pulse: request accepted and latched
//  done0/1     out  1       one-cycle pulse: access complete
//  rdata0/1    out  WORD_W  read data; valid with doneN for reads
//  mem_cs      out  1       RAM chip select
//  mem_rnw     out  1       RAM read/not-write
//  mem_addr    out  ADDR_W  RAM address
//  mem_wdata   out  WORD_W  RAM write data
//  mem_rdata   in   WORD_W  RAM read data, one cycle after mem_cs read
// BEHAVIOUR
//  - Reset: async, active-low, on clock. State IDLE. last_grant = 1, so port 0
//    wins the first tie. All outputs 0, including rdata0/1 and mem_*.
//  - All outputs are registered. There are no combinational paths from inputs
//    to outputs.
//  - FSM states: IDLE -> ACCESS -> COMPLETE -> IDLE.
//  - IDLE (cycle T): if req0 or req1, select the winner. Latch its rnw, addr and
//    wdata plus the port id. Next state ACCESS. If neither is requesting, stay.
//  - Winner selection: only one requesting -> that port. Both requesting ->
//    the port != last_grant when FIXED_PRIO = 0, otherwise port 0.
//    last_grant updates to the winner.
//  - ACCESS (T+1): gntN = 1 for the winner. mem_cs = 1, plus mem_rnw, mem_addr
//    and mem_wdata from the latched values. Next state COMPLETE.
//  - COMPLETE (T+2): mem_cs = 0. For a read, capture mem_rdata into rdataN at
//    the end of T+2. Next state IDLE.
//  - T+3 (IDLE): doneN = 1 for one cycle; rdataN is valid. A new arbitration is
//    allowed in this same cycle.
//  - Throughput is one access per 3 cycles. Writes follow identical timing:
//    mem_cs in T+1, done in T+3.
//  - rdataN holds its value until the next read on that port. Writes never
//    modify rdataN.
//  - Requester rules: reqN must be deasserted no later than the done cycle.
//    A reqN still high in IDLE is a new request. A reqN dropped before gntN is
//    simply not served; no error is raised.
//  - Only the latched port sees gnt/done. The losing port's req stays pending
//    and it wins the next IDLE under round-robin.
//  - Under round-robin, with both ports held continuously, grants alternate
//    0,1,0,1. Maximum wait is 5 cycles from req to gnt.
//  - Reset mid-access: the access is abandoned, with no done pulse. mem_cs
//    drops immediately (async). Partially performed RAM writes are not undone.
//  - Address and data pass through unmodified. Widths match exactly, with no
//    truncation or extension.
// TESTING
//  1. Port 0 read: req0=1, rnw0=1, addr0=5'h03, RAM[3]=8'hA5 -> gnt0 at T+1
//     with mem_cs=1, mem_addr=3, mem_rnw=1; done0 at T+3 with rdata0=8'hA5.
//  2. Port 1 write: addr1=5'h1F, wdata1=8'h3C -> mem_cs=1, mem_rnw=0,
//     mem_wdata=8'h3C at T+1; done1 at T+3; read back via port 0 returns 8'h3C.
//  3. Both ports request together from reset, FIXED_PRIO=0 -> gnt0 first, then
//     gnt1 at T+4; held 12 cycles -> grant order 0,1,0,1.
//  4. FIXED_PRIO=1 with both ports requesting continuously -> port 0 always
//     granted; port 1 granted only after req0 drops.
//  5. Assert n_reset low during ACCESS of a write -> mem_cs, gnt and done are
//     all 0 immediately; no done pulse after release; next request starts
//     from IDLE with port 0 priority.
//  6. Pulse req1 for 1 cycle while port 0 is being served -> no gnt1/done1;
//     rdata1 unchanged at 8'h00.

Source files
------------

// File: rtl/ram_arbiter.sv
// ram_arbiter
//   Shares one single-port synchronous RAM between two requesters.
//   Port 0 is the processor memory interface. Port 1 is the display/DMA reader.
//   Only one access is in flight at a time: IDLE -> ACCESS -> COMPLETE -> IDLE,
//   which gives one access every three cycles. Every output is registered, so
//   there is no combinational path from any input to any output.
//
// Ports
//   clock, n_reset          rising-edge clock, asynchronous active-low reset
//   reqN/rnwN/addrN/wdataN  request and its attributes (N = 0, 1); reqN is held
//                           until gntN is seen
//   gntN                    one-cycle pulse in the ACCESS cycle of the winner
//   doneN                   one-cycle pulse in the cycle after COMPLETE
//   rdataN                  read data; valid with doneN and held until the next
//                           read on that port
//   mem_cs/mem_rnw/mem_addr/mem_wdata   RAM command, driven in ACCESS only
//   mem_rdata               RAM read data, one cycle after a mem_cs read
//   dbg_state               current FSM state (0 IDLE, 1 ACCESS, 2 COMPLETE)
//
// Handshake: a request is taken in the cycle it is seen high while the FSM is
// IDLE. Acceptance is signalled by gntN one cycle later, and completion by
// doneN two cycles after that. A reqN that is still high in an IDLE cycle,
// including the doneN cycle, counts as a new request. A request that drops
// before it is granted is forgotten without any error.
module ram_arbiter #(
  parameter int WORD_W     = 8,
  parameter int ADDR_W     = 5,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              rnw0,
  input  logic              rnw1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [WORD_W-1:0] wdata0,
  input  logic [WORD_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic [WORD_W-1:0] rdata0,
  output logic [WORD_W-1:0] rdata1,
  output logic              mem_cs,
  output logic              mem_rnw,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACCESS   = 2'd1,
    ST_COMPLETE = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic last_grant;   // port granted most recently; resets to 1 so port 0 wins the first tie
  logic lat_port;     // port that owns the access in flight
  logic lat_rnw;      // direction of the access in flight
  logic win_port;
  logic load_en;
  logic cap_en;

  assign dbg_state = state;

  // Winner selection. When both ports request, round-robin picks the port
  // that was not granted last. Fixed priority always picks port 0.
  always_comb begin
    win_port = 1'b0;
    if (req0 && req1) begin
      win_port = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    end else if (req1) begin
      win_port = 1'b1;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    cap_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req0 || req1) begin
          load_en   = 1'b1;
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        state_nxt = ST_COMPLETE;
      end
      ST_COMPLETE: begin
        cap_en    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath and output registers. The mem_* registers double as the latch
  // for the winning address and write data. They are loaded at the end of the
  // IDLE cycle, so the RAM sees the latched command during ACCESS.
  // gnt, done and mem_cs are pulses: they default to 0 on every clock.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      last_grant <= 1'b1;
      lat_port   <= 1'b0;
      lat_rnw    <= 1'b0;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      mem_cs     <= 1'b0;
      mem_rnw    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done0  <= 1'b0;
      done1  <= 1'b0;
      mem_cs <= 1'b0;

      if (load_en) begin
        last_grant <= win_port;
        lat_port   <= win_port;
        lat_rnw    <= win_port ? rnw1 : rnw0;
        gnt0       <= ~win_port;
        gnt1       <= win_port;
        mem_cs     <= 1'b1;
        mem_rnw    <= win_port ? rnw1 : rnw0;
        mem_addr   <= win_port ? addr1 : addr0;
        mem_wdata  <= win_port ? wdata1 : wdata0;
      end

      // The RAM returns read data during COMPLETE. It is captured at the end
      // of COMPLETE, so it is valid together with the done pulse.
      if (cap_en) begin
        if (lat_port) begin
          done1 <= 1'b1;
          if (lat_rnw) begin
            rdata1 <= mem_rdata;
          end
        end else begin
          done0 <= 1'b1;
          if (lat_rnw) begin
            rdata0 <= mem_rdata;
          end
        end
      end
    end
  end

endmodule
